// File: rtl/mem_access_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_access_if : data-bus request/acknowledge bundle between MEM and memory  |
// | Revision      : 1.0                                                         |
// +----------------------------------------------------------------------------+
interface mem_access_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_access : MIPS32 MEM stage, bus load/store FSM with pipeline stall       |
// | Optional   : MEM_ALIGN_CHECK_EN traps misaligned halfword/word accesses     |
// | Revision   : 1.0                                                            |
// +----------------------------------------------------------------------------+
module mem_access (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [4:0]          ex_dest_addr,
  input  logic                ex_wreg,
  input  logic [31:0]         ex_dest_data,
  input  logic [31:0]         ex_hi,
  input  logic [31:0]         ex_lo,
  input  logic                ex_whilo,
  input  logic [3:0]          ex_mem_op,
  input  logic [31:0]         ex_mem_addr,
  input  logic [31:0]         ex_store_data,
  mem_access_if.master        bus,
  output logic [4:0]          mem_dest_addr,
  output logic                mem_wreg,
  output logic [31:0]         mem_dest_data,
  output logic [31:0]         mem_hi,
  output logic [31:0]         mem_lo,
  output logic                mem_whilo,
  output logic                mem_addr_exc,
  output logic                stall_req
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_BUSY = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;
  localparam logic [1:0] c_DROP = 2'd3;

  localparam logic [3:0] c_OP_LB  = 4'd1;
  localparam logic [3:0] c_OP_LBU = 4'd2;
  localparam logic [3:0] c_OP_LH  = 4'd3;
  localparam logic [3:0] c_OP_LHU = 4'd4;
  localparam logic [3:0] c_OP_LW  = 4'd5;
  localparam logic [3:0] c_OP_SB  = 4'd6;
  localparam logic [3:0] c_OP_SH  = 4'd7;
  localparam logic [3:0] c_OP_SW  = 4'd8;

  localparam logic [4:0] c_NOP_REG_ADDR = 5'd0;

  logic [1:0]  state_q, state_d;
  logic [31:0] ld_data_q, ld_data_d;
  logic        flush_pend_q, flush_pend_d;

  logic        w_is_load, w_is_store, w_is_mem;
  logic        w_misaligned, w_start, w_req_active;
  logic [3:0]  w_sel;
  logic [31:0] w_wdata;
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;
  logic [31:0] w_ld_val;

  assign w_is_load  = (ex_mem_op >= c_OP_LB) && (ex_mem_op <= c_OP_LW);
  assign w_is_store = (ex_mem_op >= c_OP_SB) && (ex_mem_op <= c_OP_SW);
  assign w_is_mem   = w_is_load || w_is_store;

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misaligned =
      (((ex_mem_op == c_OP_LH) || (ex_mem_op == c_OP_LHU) || (ex_mem_op == c_OP_SH))
        && ex_mem_addr[0]) ||
      (((ex_mem_op == c_OP_LW) || (ex_mem_op == c_OP_SW)) && (ex_mem_addr[1:0] != 2'b00));
`else
  assign w_misaligned = 1'b0;
`endif

  // A flushed or trapped instruction never opens a bus transaction.
  assign w_start      = (state_q == c_IDLE) && w_is_mem && !flush && !w_misaligned;
  assign w_req_active = w_start || (state_q == c_BUSY);

  // Big-endian lanes: address 0 maps to bits [31:24].
  always_comb begin
    w_sel   = 4'b0000;
    w_wdata = ex_store_data;
    case (ex_mem_op)
      c_OP_LB, c_OP_LBU, c_OP_SB: w_sel = 4'b1000 >> ex_mem_addr[1:0];
      c_OP_LH, c_OP_LHU, c_OP_SH: w_sel = ex_mem_addr[1] ? 4'b0011 : 4'b1100;
      c_OP_LW, c_OP_SW:           w_sel = 4'b1111;
      default:                    w_sel = 4'b0000;
    endcase
    if (ex_mem_op == c_OP_SB) begin
      w_wdata = {4{ex_store_data[7:0]}};
    end else if (ex_mem_op == c_OP_SH) begin
      w_wdata = {2{ex_store_data[15:0]}};
    end
  end

  always_comb begin
    w_ld_byte = ld_data_q[31:24];
    case (ex_mem_addr[1:0])
      2'b00:   w_ld_byte = ld_data_q[31:24];
      2'b01:   w_ld_byte = ld_data_q[23:16];
      2'b10:   w_ld_byte = ld_data_q[15:8];
      default: w_ld_byte = ld_data_q[7:0];
    endcase
    w_ld_half = ex_mem_addr[1] ? ld_data_q[15:0] : ld_data_q[31:16];
    case (ex_mem_op)
      c_OP_LB:  w_ld_val = {{24{w_ld_byte[7]}}, w_ld_byte};
      c_OP_LBU: w_ld_val = {24'd0, w_ld_byte};
      c_OP_LH:  w_ld_val = {{16{w_ld_half[15]}}, w_ld_half};
      c_OP_LHU: w_ld_val = {16'd0, w_ld_half};
      default:  w_ld_val = ld_data_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= c_IDLE;
      ld_data_q    <= 32'd0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ld_data_q    <= ld_data_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ld_data_d    = ld_data_q;
    flush_pend_d = 1'b0;
    if (w_req_active && bus.bus_ack) begin
      ld_data_d = bus.bus_rdata;
    end
    case (state_q)
      c_IDLE: begin
        if (w_start) begin
          state_d = bus.bus_ack ? c_DONE : c_BUSY;
        end
      end
      c_BUSY: begin
        // The bus cycle must finish; a flush seen meanwhile turns DONE into DROP.
        if (bus.bus_ack) begin
          state_d = (flush || flush_pend_q) ? c_DROP : c_DONE;
        end else begin
          flush_pend_d = flush || flush_pend_q;
        end
      end
      c_DONE:  state_d = c_IDLE;
      c_DROP:  state_d = c_IDLE;
      default: state_d = c_IDLE;
    endcase
  end

  always_comb begin
    bus.bus_req   = 1'b0;
    bus.bus_we    = 1'b0;
    bus.bus_addr  = 32'd0;
    bus.bus_sel   = 4'b0000;
    bus.bus_wdata = 32'd0;
    mem_dest_addr = c_NOP_REG_ADDR;
    mem_wreg      = 1'b0;
    mem_dest_data = 32'd0;
    mem_hi        = 32'd0;
    mem_lo        = 32'd0;
    mem_whilo     = 1'b0;
    mem_addr_exc  = 1'b0;
    stall_req     = 1'b0;
    if (rst) begin
      bus.bus_we    = w_is_store;
      bus.bus_addr  = {ex_mem_addr[31:2], 2'b00};
      bus.bus_sel   = w_sel;
      bus.bus_wdata = w_wdata;
      mem_dest_addr = ex_dest_addr;
      mem_wreg      = ex_wreg;
      mem_dest_data = ex_dest_data;
      mem_hi        = ex_hi;
      mem_lo        = ex_lo;
      mem_whilo     = ex_whilo;
      case (state_q)
        c_IDLE: begin
          if (flush) begin
            mem_wreg  = 1'b0;
            mem_whilo = 1'b0;
          end else if (w_misaligned) begin
            mem_addr_exc = 1'b1;
            mem_wreg     = 1'b0;
          end else if (w_is_mem) begin
            bus.bus_req = 1'b1;
            stall_req   = 1'b1;
            mem_wreg    = 1'b0;
            mem_whilo   = 1'b0;
          end
        end
        c_BUSY: begin
          bus.bus_req = 1'b1;
          stall_req   = 1'b1;
          mem_wreg    = 1'b0;
          mem_whilo   = 1'b0;
        end
        c_DONE: begin
          if (w_is_load) begin
            mem_dest_data = w_ld_val;
          end
          if (w_is_store || flush) begin
            mem_wreg = 1'b0;
          end
          if (flush) begin
            mem_whilo = 1'b0;
          end
        end
        default: begin
          mem_wreg  = 1'b0;
          mem_whilo = 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/mem_access.md
# mem_access

MEM stage of the MIPS32 pipeline. It sits between the EX/MEM register and `mem_wb`. Non-memory instructions pass through combinationally. Loads and stores run a data-bus request/acknowledge transaction. The block holds the pipeline with `stall_req` until the load result or the store completion is ready for `mem_wb` to capture.

## Interface
- No parameters. Widths come from `RegBus` (32) and `RegAddrBus` (5).
- `clk` in 1: the only clock; rising edge.
- `rst` in 1: synchronous, active-low reset.
- `flush` in 1: squash the current MEM instruction.
- `ex_dest_addr` in 5, `ex_wreg` in 1, `ex_dest_data` in 32: register write request from EX/MEM.
- `ex_hi` in 32, `ex_lo` in 32, `ex_whilo` in 1: HI/LO write request.
- `ex_mem_op` in 4: 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW. Values 9–15 are treated as none.
- `ex_mem_addr` in 32: effective address.
- `ex_store_data` in 32: rt value for stores.
- `bus_req` out 1: request; held until `bus_ack`.
- `bus_we` out 1: 1 for stores.
- `bus_addr` out 32: word-aligned address (low 2 bits = 0).
- `bus_sel` out 4: byte enables; bit3 = bits[31:24].
- `bus_wdata` out 32: store data.
- `bus_ack` in 1: completes the transaction in the cycle it is high while `bus_req` = 1.
- `bus_rdata` in 32: read data, valid while `bus_ack` = 1.
- `mem_dest_addr` out 5, `mem_wreg` out 1, `mem_dest_data` out 32: to `mem_wb`.
- `mem_hi` out 32, `mem_lo` out 32, `mem_whilo` out 1: to `mem_wb`.
- `mem_addr_exc` out 1: misaligned access flag (see Configuration).
- `stall_req` out 1: hold IF through MEM.

## Operation
- States: IDLE, BUSY, DONE, DROP. The state and a 32-bit `ld_data` register are the only storage.
- **IDLE, op none:**
  - All `ex_*` fields pass to the `mem_*` outputs.
  - `bus_req` = 0, `stall_req` = 0.
- **IDLE, memory op:**
  - `bus_req` = 1 and `stall_req` = 1 in the same cycle.
  - Next state is BUSY, or DONE if `bus_ack` is already high.
  - `mem_wreg` and `mem_whilo` = 0 while stalled.
- **BUSY:** bus outputs stay driven from the (held) `ex_*` inputs and `stall_req` = 1. On `bus_ack`:
  - Capture `bus_rdata` into `ld_data`.
  - Go to DONE.
- **DONE:**
  - `bus_req` = 0, `stall_req` = 0.
  - Outputs carry the instruction's result: `ld_data` extracted for loads; `mem_wreg` = 0 for stores.
  - Next state is unconditionally IDLE.
- **Lanes are big-endian.**
  - Byte at `addr[1:0]` = 00 uses `sel` 1000 and bits[31:24]. 01 → 0100, 10 → 0010, 11 → 0001.
  - Halfword at `addr[1]` = 0 uses `sel` 1100; `addr[1]` = 1 uses 0011.
  - Word uses 1111.
- **Store data:**
  - SB replicates byte `store_data[7:0]` into all four lanes.
  - SH replicates halfword `store_data[15:0]` into both halves.
- **Load extension:**
  - LB and LH sign-extend the selected lane.
  - LBU and LHU zero-extend the selected lane.
- **Flush:**
  - In IDLE or DONE: all `mem_*` write enables = 0 that cycle; next state is IDLE.
  - In BUSY: the bus transaction cannot be abandoned. The flush is remembered, and on `bus_ack` the FSM goes to DROP instead of DONE.
  - DROP outputs a bubble with `stall_req` = 0, then returns to IDLE.
- **Reset:** the FSM returns to IDLE and `ld_data` = 0 at the next edge with `rst` = 0, even in the middle of BUSY. Every output is forced to 0 while `rst` = 0, including:
  - `bus_req`, `stall_req`, `mem_wreg`, `mem_whilo`, `mem_addr_exc`.
  - All data outputs and `mem_dest_addr` (`NOPRegAddr`).

## Timing
- Pass-through latency is 0 cycles (combinational).
- A memory op with an ack in its first cycle stalls for exactly 1 cycle. Its result is visible in the DONE cycle, and `mem_wb` captures it at the end of that cycle.
- With N wait cycles before the ack, the stall lasts N+1 cycles.
- `bus_req` never deasserts before `bus_ack`.
- `bus_req` is 0 in DONE and DROP, so back-to-back memory ops are separated by at least one cycle with `bus_req` low.
- `bus_ack` while `bus_req` = 0 is ignored.

## Configuration
- **`MEM_ALIGN_CHECK_EN` defined:**
  - LH/LHU/SH with `addr[0]` = 1, or LW/SW with `addr[1:0]` ≠ 0, issues no bus request and causes no stall.
  - It sets `mem_addr_exc` = 1 and `mem_wreg` = 0 for that cycle.
- **Undefined:**
  - The offending low address bits are treated as 0: halfword uses `addr[1]` only, word uses 1111.
  - `mem_addr_exc` is tied to 0.

## Test plan
- **ADD pass-through:** `ex_wreg` = 1, `ex_dest_addr` = 5, `ex_dest_data` = 0x1234, op none → same values on outputs in the same cycle; `stall_req` = 0, `bus_req` = 0.
- **LB, zero-wait ack:** LB at 0x1001, ack in cycle 0, `bus_rdata` = 0x11F23344 → `bus_sel` = 0100, `stall_req` = 1 for 1 cycle; DONE outputs `mem_dest_data` = 0xFFFFFFF2.
- **LHU with 3 wait cycles:** LHU at 0x2002, `bus_rdata` = 0xAAAA8001 → `stall_req` high for 4 cycles; `mem_dest_data` = 0x00008001.
- **SB:** SB at 0x3003, `ex_store_data` = 0x000000AB → `bus_we` = 1, `bus_sel` = 0001, `bus_wdata` = 0xABABABAB, `bus_addr` = 0x3000; DONE has `mem_wreg` = 0.
- **Flush mid-BUSY:** flush during BUSY of an LW, then ack → next cycle `mem_wreg` = 0, `stall_req` = 0; IDLE follows.
- **Misaligned LW and reset:** LW at 0x4002 → with `MEM_ALIGN_CHECK_EN`, `mem_addr_exc` = 1 and no `bus_req`; without it, `bus_addr` = 0x4000 with `bus_sel` = 1111. Then `rst` = 0 during BUSY → all outputs 0 and state IDLE the following cycle.
